// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified I/D memory arbiter.
package unified_mem_arbiter_pkg;

  // Arbiter sequencing states: idle/issue, or waiting on a fetch or data read.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRdI  = 2'd1,
    StRdD  = 2'd2
  } arb_state_e;

  // Supported RAM read latency range; the latency counter is sized for the maximum.
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;
  localparam int unsigned LatCntW  = 2;

  localparam int unsigned DataW = 32;

  // Width needed to hold a streak count of 0..max_streak.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    if (max_streak < 2) begin
      return 1;
    end
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_lat_cnt.sv
// Loadable down-counter timing an outstanding RAM read.
// Loaded with the read latency on the issue edge; done_o marks the cycle in which
// the RAM read data is valid and must be captured.
module unified_mem_arbiter_lat_cnt
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned Width = LatCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: load on issue, otherwise count down to zero and stay there.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  // Count register; a reset aborts any read in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Final wait cycle: a count of one means the RAM output is valid now.
  assign done_o = (count_q == Width'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (I) and data (D).
// One read is outstanding at a time; writes complete in their issue cycle. D has
// priority, but after MAX_D_STREAK consecutive D grants with a fetch waiting, I wins.
// RD_LAT must lie in 1..3.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DataW-1:0]  i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DataW-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DataW-1:0]  d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DataW-1:0]  ram_wdata,
  input  logic [DataW-1:0]  ram_rdata,
  output logic              busy
);

  localparam int unsigned         StreakW   = streak_width(MAX_D_STREAK);
  localparam logic [StreakW-1:0]  StreakMax = StreakW'(MAX_D_STREAK);
  localparam logic [LatCntW-1:0]  LatLoad   = LatCntW'(RD_LAT);

  arb_state_e         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               d_win, i_win;
  logic               issue_rd;
  logic               lat_done;
  logic               i_rvalid_q, d_rvalid_q;
  logic [DataW-1:0]   i_rdata_q, d_rdata_q;

  // Byte-offset and high address bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  // Arbitration, RAM issue and next state; everything combinational is forced low in reset.
  always_comb begin
    state_d   = state_q;
    d_win     = 1'b0;
    i_win     = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      StIdle: begin
        // D wins unless a waiting fetch has already sat out a full D streak.
        d_win = d_req && !(i_req && (streak_q == StreakMax));
        i_win = i_req && !d_win;
        if (d_win) begin
          d_gnt    = 1'b1;
          ram_en   = 1'b1;
          ram_we   = d_we;
          ram_addr = d_addr[ADDR_W+1:2];
          if (d_we) begin
            ram_wdata = d_wdata;
          end else begin
            state_d = StRdD;
          end
        end else if (i_win) begin
          i_gnt    = 1'b1;
          ram_en   = 1'b1;
          ram_addr = i_addr[ADDR_W+1:2];
          state_d  = StRdI;
        end
      end
      StRdI, StRdD: begin
        if (lat_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (!rst) begin
      state_d   = StIdle;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  assign issue_rd = i_gnt || (d_gnt && !d_we);

  // Streak of D grants taken while a fetch waits; cleared once I is served or stops asking.
  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  unified_mem_arbiter_lat_cnt #(
    .Width(LatCntW)
  ) u_lat_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (issue_rd),
    .load_val_i (LatLoad),
    .done_o     (lat_done)
  );

  // FSM state and streak registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Capture read data on the last wait cycle; rvalid pulses the cycle after, back in idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= (state_q == StRdI) && lat_done;
      d_rvalid_q <= (state_q == StRdD) && lat_done;
      if ((state_q == StRdI) && lat_done) begin
        i_rdata_q <= ram_rdata;
      end
      if ((state_q == StRdD) && lat_done) begin
        d_rdata_q <= ram_rdata;
      end
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != StIdle);

endmodule
